// File: rtl/vector_player_checker.sv
// vector_player_checker: plays stored stimulus vectors into a DUT, samples the
// response after a programmable settle time and checks it against a masked
// expected value, reporting error count, first failing index and pass/fail.
// Vector RAM word layout: {stim[IN_WIDTH], expected[OUT_WIDTH], mask[OUT_WIDTH]}.
// Optional feature macro: VPC_LOOP_EN adds a LOOP input that replays the vector
// list continuously (errors accumulate) until ABORT or reset.
module vector_player_checker #(
    parameter int unsigned IN_WIDTH  = 9,
    parameter int unsigned OUT_WIDTH = 4,
    parameter int unsigned DEPTH     = 100,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                              CLK,
    input  logic                              RSTN,
    input  logic                              LD_WE,
    input  logic [ADDR_W-1:0]                 LD_ADDR,
    input  logic [IN_WIDTH+2*OUT_WIDTH-1:0]   LD_DATA,
    input  logic [ADDR_W-1:0]                 LAST_IDX,
    input  logic                              START,
    input  logic                              ABORT,
`ifdef VPC_LOOP_EN
    input  logic                              LOOP,
`endif
    input  logic [OUT_WIDTH-1:0]              DUT_Q,
    output logic [IN_WIDTH-1:0]               STIM,
    output logic                              BUSY,
    output logic                              DONE,
    output logic                              PASS,
    output logic [CNT_W-1:0]                  ERR_CNT,
    output logic [ADDR_W-1:0]                 FAIL_IDX,
    output logic [ADDR_W-1:0]                 VEC_IDX
);

    localparam int unsigned WORD_W = IN_WIDTH + 2 * OUT_WIDTH;
    localparam int unsigned SET_W  = 8;
    localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRIVE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [WORD_W-1:0]     mem [DEPTH];
    logic [WORD_W-1:0]     rd_c;
    logic [OUT_WIDTH-1:0]  exp_q, mask_q;
    logic [ADDR_W-1:0]     last_q, last_nxt;
    logic [SET_W-1:0]      settle_q, settle_nxt;
    logic [ADDR_W-1:0]     vec_idx_nxt, fail_idx_nxt;
    logic [CNT_W-1:0]      err_cnt_nxt;
    logic                  busy_nxt, done_nxt, pass_nxt;
    logic                  run_c, abort_c, is_last_c, mismatch_c, loop_c;

`ifdef VPC_LOOP_EN
    assign loop_c = LOOP;
`else
    assign loop_c = 1'b0;
`endif

    assign run_c      = (state == S_FETCH) || (state == S_DRIVE) || (state == S_CHECK);
    assign abort_c    = run_c && ABORT;
    assign is_last_c  = (VEC_IDX == last_q);
    assign mismatch_c = |((DUT_Q ^ exp_q) & mask_q);
    assign rd_c       = mem[VEC_IDX];

    // Vector RAM write port; loads are ignored during a run and beyond DEPTH
    always_ff @(posedge CLK) begin
        if (LD_WE && !BUSY && (32'(LD_ADDR) < DEPTH)) begin
            mem[LD_ADDR] <= LD_DATA;
        end
    end

    // Registered read of expected/mask, captured while fetching
    always_ff @(posedge CLK) begin
        if (state == S_FETCH) begin
            exp_q  <= rd_c[2*OUT_WIDTH-1:OUT_WIDTH];
            mask_q <= rd_c[OUT_WIDTH-1:0];
        end
    end

    // Stimulus register: loaded from the same read on DRIVE entry, cleared by abort
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            STIM <= '0;
        end else if (abort_c) begin
            STIM <= '0;
        end else if (state == S_FETCH) begin
            STIM <= rd_c[WORD_W-1 -: IN_WIDTH];
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort of a running sequence overrides everything
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (START) state_nxt = S_FETCH;
            S_FETCH:        state_nxt = S_DRIVE;
            S_DRIVE:        if (settle_q == '0) state_nxt = S_CHECK;
            S_CHECK:        state_nxt = (is_last_c && !loop_c) ? S_DONE : S_FETCH;
            default:        state_nxt = S_IDLE;
        endcase
        if (abort_c) begin
            state_nxt = S_IDLE;
        end
    end

    // Next values of the counters and status outputs
    always_comb begin
        vec_idx_nxt  = VEC_IDX;
        err_cnt_nxt  = ERR_CNT;
        fail_idx_nxt = FAIL_IDX;
        last_nxt     = last_q;
        settle_nxt   = settle_q;
        if (!abort_c) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        vec_idx_nxt  = '0;
                        err_cnt_nxt  = '0;
                        fail_idx_nxt = '0;
                        last_nxt     = (32'(LAST_IDX) > DEPTH - 1) ? LAST_MAX : LAST_IDX;
                    end
                end
                S_FETCH: settle_nxt = SET_W'(SETTLE - 1);
                S_DRIVE: if (settle_q != '0) settle_nxt = settle_q - SET_W'(1);
                S_CHECK: begin
                    if (mismatch_c) begin
                        if (ERR_CNT == '0) fail_idx_nxt = VEC_IDX;
                        if (ERR_CNT != {CNT_W{1'b1}}) err_cnt_nxt = ERR_CNT + CNT_W'(1);
                    end
                    if (!is_last_c) begin
                        vec_idx_nxt = VEC_IDX + ADDR_W'(1);
                    end else if (loop_c) begin
                        vec_idx_nxt = '0;
                    end
                end
                default: ;
            endcase
        end
        busy_nxt = (state_nxt == S_FETCH) || (state_nxt == S_DRIVE) || (state_nxt == S_CHECK);
        done_nxt = (state_nxt == S_DONE);
        pass_nxt = (state_nxt == S_DONE) && (err_cnt_nxt == '0);
    end

    // Output and counter registers
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            VEC_IDX  <= '0;
            ERR_CNT  <= '0;
            FAIL_IDX <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
            last_q   <= '0;
            settle_q <= '0;
        end else begin
            VEC_IDX  <= vec_idx_nxt;
            ERR_CNT  <= err_cnt_nxt;
            FAIL_IDX <= fail_idx_nxt;
            BUSY     <= busy_nxt;
            DONE     <= done_nxt;
            PASS     <= pass_nxt;
            last_q   <= last_nxt;
            settle_q <= settle_nxt;
        end
    end

endmodule

// File: tb/tb_vector_player_checker.sv
// Bench for vector_player_checker: a time-based reference model predicts every
// output each cycle from the run start time; directed scenarios add literal checks.
module tb_vector_player_checker;

    localparam int unsigned IN_W   = 9;
    localparam int unsigned OUT_W  = 4;
    localparam int unsigned DEPTH  = 100;
    localparam int unsigned AW     = 7;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned CW     = 2;
    localparam int unsigned WW     = IN_W + 2 * OUT_W;
    localparam int unsigned P      = SETTLE + 2;
    localparam int unsigned ERRMAX = (1 << CW) - 1;

    logic            CLK = 1'b0;
    logic            RSTN, LD_WE, START, ABORT;
    logic            LOOP = 1'b0;
    logic [AW-1:0]   LD_ADDR, LAST_IDX;
    logic [WW-1:0]   LD_DATA;
    logic [OUT_W-1:0] DUT_Q;
    logic [IN_W-1:0] STIM;
    logic            BUSY, DONE, PASS;
    logic [CW-1:0]   ERR_CNT;
    logic [AW-1:0]   FAIL_IDX, VEC_IDX;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int stim_log [0:1023];

    always #5 CLK = ~CLK;

    // Toy DUT driven by the player
    function automatic logic [OUT_W-1:0] dut_f(input logic [IN_W-1:0] s);
        return s[3:0] ^ s[7:4] ^ {3'b000, s[8]};
    endfunction
    assign DUT_Q = dut_f(STIM);

    vector_player_checker #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEPTH(DEPTH), .ADDR_W(AW),
        .SETTLE(SETTLE), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
        .LAST_IDX(LAST_IDX), .START(START), .ABORT(ABORT),
`ifdef VPC_LOOP_EN
        .LOOP(LOOP),
`endif
        .DUT_Q(DUT_Q), .STIM(STIM), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .ERR_CNT(ERR_CNT), .FAIL_IDX(FAIL_IDX), .VEC_IDX(VEC_IDX)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs derived from edges elapsed since the START edge
    logic [WW-1:0]   mem_m [DEPTH];
    bit              m_busy, m_done, m_pass, m_pend;
    logic [IN_W-1:0] m_stim;
    int unsigned     m_err, m_fidx, m_vidx, m_t, m_n;

    always @(posedge CLK) begin : model
        logic [WW-1:0] w;
        bit wr_ok;
        wr_ok = LD_WE && !m_busy && (32'(LD_ADDR) < DEPTH);
        if (!RSTN) begin
            m_busy = 0; m_done = 0; m_pass = 0; m_stim = '0;
            m_err = 0; m_fidx = 0; m_vidx = 0; m_t = 0;
        end else if (m_busy && ABORT) begin
            m_busy = 0; m_done = 0; m_pass = 0; m_stim = '0;
        end else if (!m_busy && START) begin
            m_n = ((32'(LAST_IDX) > DEPTH - 1) ? DEPTH - 1 : 32'(LAST_IDX)) + 1;
            m_t = 0; m_busy = 1; m_done = 0; m_pass = 0;
            m_vidx = 0; m_err = 0; m_fidx = 0;
        end else if (m_busy) begin
            m_t++;
            if (m_t % P == 1) begin
                w = mem_m[(m_t - 1) / P];
                m_stim = w[WW-1 -: IN_W];
                m_pend = |((dut_f(m_stim) ^ w[2*OUT_W-1:OUT_W]) & w[OUT_W-1:0]);
            end
            if (m_t % P == 0) begin
                if (m_pend) begin
                    if (m_err == 0) m_fidx = m_t / P - 1;
                    if (m_err < ERRMAX) m_err++;
                end
                if (m_t == m_n * P) begin
                    if (LOOP) m_t = 0;
                    else begin
                        m_busy = 0; m_done = 1; m_pass = (m_err == 0);
                    end
                end
            end
            m_vidx = m_busy ? m_t / P : m_n - 1;
        end
        if (wr_ok) mem_m[LD_ADDR] = LD_DATA;
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            check("STIM", 32'(STIM), 32'(m_stim));
            check("BUSY", 32'(BUSY), 32'(m_busy));
            check("DONE", 32'(DONE), 32'(m_done));
            check("PASS", 32'(PASS), 32'(m_pass));
            check("ERR_CNT", 32'(ERR_CNT), m_err);
            check("FAIL_IDX", 32'(FAIL_IDX), m_fidx);
            check("VEC_IDX", 32'(VEC_IDX), m_vidx);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input int a, input logic [IN_W-1:0] s,
                        input logic [OUT_W-1:0] e, input logic [OUT_W-1:0] m);
        LD_WE = 1'b1; LD_ADDR = AW'(a); LD_DATA = {s, e, m};
        step();
        LD_WE = 1'b0;
    endtask

    task automatic load_good(input int a, input logic [IN_W-1:0] s);
        load(a, s, dut_f(s), 4'hF);
    endtask

    task automatic start_run(input int last);
        LAST_IDX = AW'(last); START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!DONE && cyc < 5000) begin
            step();
            cyc++;
            if (cyc < 1024) stim_log[cyc] = 32'(STIM);
        end
        if (!DONE) check("done_timeout", 32'(DONE), 32'd1);
    endtask

    logic [IN_W-1:0] sv [8];
    int cyc;

    initial begin
        sv[0] = 9'h1A5; sv[1] = 9'h05A; sv[2] = 9'h133; sv[3] = 9'h0CC;
        sv[4] = 9'h011; sv[5] = 9'h122; sv[6] = 9'h0F0; sv[7] = 9'h1FF;
        RSTN = 1'b0; LD_WE = 1'b0; START = 1'b0; ABORT = 1'b0;
        LD_ADDR = '0; LD_DATA = '0; LAST_IDX = '0;
        step(); step();
        chk_en = 1'b1;
        check("rst_stim", 32'(STIM), 0);
        check("rst_busy_done", 32'({BUSY, DONE, PASS}), 0);
        check("rst_cnt", 32'({ERR_CNT, FAIL_IDX, VEC_IDX}), 0);
        RSTN = 1'b1;

        // All-pass run of four vectors
        for (int i = 0; i < 8; i++) load_good(i, sv[i]);
        start_run(3);
        wait_done(cyc);
        check("t1_latency", cyc, 24);
        check("t1_pass", 32'(PASS), 1);
        check("t1_err", 32'(ERR_CNT), 0);
        for (int k = 0; k < 4; k++) begin
            check("t1_stim_first", stim_log[6*k+1], 32'(sv[k]));
            check("t1_stim_last", stim_log[6*k+6], 32'(sv[k]));
        end

        // Corrupted expected values at 2 and 5
        load(2, sv[2], dut_f(sv[2]) ^ 4'h1, 4'hF);
        load(5, sv[5], dut_f(sv[5]) ^ 4'h1, 4'hF);
        start_run(7);
        wait_done(cyc);
        check("t2_latency", cyc, 48);
        check("t2_err", 32'(ERR_CNT), 2);
        check("t2_fidx", 32'(FAIL_IDX), 2);
        check("t2_pass", 32'(PASS), 0);

        // Same corruption masked off
        load(2, sv[2], dut_f(sv[2]) ^ 4'h1, 4'h0);
        load(5, sv[5], dut_f(sv[5]) ^ 4'h1, 4'h0);
        start_run(7);
        wait_done(cyc);
        check("t3_err", 32'(ERR_CNT), 0);
        check("t3_pass", 32'(PASS), 1);

        // Six failures saturate a 2-bit counter
        for (int i = 0; i < 6; i++) load(i, sv[i], dut_f(sv[i]) ^ 4'h8, 4'hF);
        start_run(5);
        wait_done(cyc);
        check("t4_sat", 32'(ERR_CNT), 3);
        check("t4_fidx", 32'(FAIL_IDX), 0);
        check("t4_pass", 32'(PASS), 0);

        // Abort in DRIVE of vector 1 with writes attempted during the run
        for (int i = 0; i < 8; i++) load_good(i, sv[i]);
        start_run(7);
        LD_WE = 1'b1; LD_ADDR = AW'(1); LD_DATA = '1;
        repeat (8) step();
        ABORT = 1'b1;
        step();
        ABORT = 1'b0; LD_WE = 1'b0;
        check("t5_busy", 32'(BUSY), 0);
        check("t5_done", 32'(DONE), 0);
        check("t5_stim", 32'(STIM), 0);
        check("t5_vidx_hold", 32'(VEC_IDX), 1);
        start_run(3);
        wait_done(cyc);
        check("t5_readback", stim_log[7], 32'(sv[1]));
        check("t5_pass", 32'(PASS), 1);

        // LAST_IDX beyond DEPTH clamps at the final entry
        for (int i = 0; i < 100; i++) load_good(i, IN_W'(i * 5 + 3));
        load_good(110, 9'h1F0);
        start_run(127);
        wait_done(cyc);
        check("t6_latency", cyc, 600);
        check("t6_vidx", 32'(VEC_IDX), 99);
        check("t6_pass", 32'(PASS), 1);

        // Reset mid-run
        start_run(127);
        repeat (50) step();
        RSTN = 1'b0;
        step();
        check("t7_stim", 32'(STIM), 0);
        check("t7_flags", 32'({BUSY, DONE, PASS}), 0);
        check("t7_cnt", 32'({ERR_CNT, FAIL_IDX, VEC_IDX}), 0);
        RSTN = 1'b1;
        step();

`ifdef VPC_LOOP_EN
        // Looping replays the list and accumulates errors
        for (int i = 0; i < 4; i++) load_good(i, sv[i]);
        load(1, sv[1], dut_f(sv[1]) ^ 4'h2, 4'hF);
        LOOP = 1'b1;
        start_run(3);
        repeat (23) step();
        check("t8_vidx_last", 32'(VEC_IDX), 3);
        step();
        check("t8_vidx_wrap", 32'(VEC_IDX), 0);
        check("t8_busy", 32'(BUSY), 1);
        check("t8_err1", 32'(ERR_CNT), 1);
        repeat (24) step();
        check("t8_err2", 32'(ERR_CNT), 2);
        check("t8_fidx", 32'(FAIL_IDX), 1);
        check("t8_nodone", 32'(DONE), 0);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0; LOOP = 1'b0;
        check("t8_abort", 32'(BUSY), 0);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
